jedro_1_excp_unit: RTL and testbench

Parametrised exception unit for the jedro_1 core. It detects misaligned jump/branch targets, misaligned load/store addresses and illegal instructions, and arbitrates them by pipeline age. It captures mepc/mcause/mtval, then sequences flush, redirect to mtvec, handler residency and mret return. It sits beside the decoder and the LSU and drives the fetch redirect path.

---
 rtl/jedro_1_excp_pkg.sv | 27 ++
 rtl/jedro_1_align_chk.sv | 32 +++
 rtl/jedro_1_excp_unit.sv | 214 +++++++++++++++++++++
 tb/tb_jedro_1_excp_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_excp_pkg.sv
// Shared cause codes, FSM states and access-size encoding for the jedro_1 exception unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jedro_1_excp_pkg;

    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4,
        ST_HALT     = 3'd5
    } excp_state_e;

    typedef enum logic [1:0] {
        LS_BYTE  = 2'd0,
        LS_HALF  = 2'd1,
        LS_WORD  = 2'd2,
        LS_DWORD = 2'd3
    } ls_size_e;

endpackage

// File: rtl/jedro_1_align_chk.sv
// Alignment checker for instruction targets (IALIGN mode) and data accesses (size mode).
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are.
module jedro_1_align_chk
    import jedro_1_excp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0] addr_i,
    input  ls_size_e   size_i,
    input  logic       inst_i,
    input  logic       ialign16_i,
    output logic       misaligned_o
);

    always_comb begin
        misaligned_o = 1'b0;
        if (inst_i) begin
            misaligned_o = ialign16_i ? addr_i[0] : (|addr_i[1:0]);
        end else begin
            unique case (size_i)
                LS_BYTE:  misaligned_o = 1'b0;
                LS_HALF:  misaligned_o = addr_i[0];
                LS_WORD:  misaligned_o = |addr_i[1:0];
                // A doubleword access on a 32-bit core has no legal alignment.
                LS_DWORD: misaligned_o = (DATA_WIDTH == 64) ? (|addr_i[2:0]) : 1'b1;
                default:  misaligned_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/jedro_1_excp_unit.sv
// Exception unit: detects misalignment/illegal faults, records the oldest, sequences flush/redirect/handler/mret.
// Latency: CSRs and flush one edge after the fault; trap redirect DRAIN_CYCLES edges later; mret return one edge.
// Backpressure: none accepted; holds the pipeline via stall_o while draining and after a double fault.
module jedro_1_excp_unit
    import jedro_1_excp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int IALIGN       = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  jmp_valid_i,
    input  logic [DATA_WIDTH-1:0] jmp_pc_i,
    input  logic [DATA_WIDTH-1:0] jmp_target_i,
    input  logic                  ls_valid_i,
    input  logic                  ls_we_i,
    input  logic [1:0]            ls_size_i,
    input  logic [DATA_WIDTH-1:0] ls_pc_i,
    input  logic [DATA_WIDTH-1:0] ls_addr_i,
    input  logic                  illegal_i,
    input  logic [DATA_WIDTH-1:0] illegal_pc_i,
    input  logic [31:0]           illegal_word_i,
    input  logic                  mret_i,
    input  logic [DATA_WIDTH-1:0] mtvec_i,
    output logic                  flush_o,
    output logic                  stall_o,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_addr_o,
    output logic [DATA_WIDTH-1:0] mepc_o,
    output logic [DATA_WIDTH-1:0] mcause_o,
    output logic [DATA_WIDTH-1:0] mtval_o,
    output logic                  trap_active_o,
    output logic                  halted_o,
    output logic [CNT_WIDTH-1:0]  excp_count_o
);

    localparam logic [2:0]            DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] VEC_MASK   = ~DATA_WIDTH'(3);
    localparam logic                  IALIGN16   = (IALIGN == 16);

    excp_state_e           r_state;
    excp_state_e           w_state_nxt;
    logic [2:0]            r_drain_cnt;
    logic [2:0]            w_drain_nxt;

    logic                  r_flush;
    logic                  r_stall;
    logic                  r_redirect_vld;
    logic [DATA_WIDTH-1:0] r_redirect_addr;
    logic [DATA_WIDTH-1:0] r_mepc;
    logic [DATA_WIDTH-1:0] r_mcause;
    logic [DATA_WIDTH-1:0] r_mtval;
    logic                  r_trap_active;
    logic                  r_halted;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_jmp_mis;
    logic                  w_ls_mis;
    logic                  w_jmp_fault;
    logic                  w_ls_fault;
    logic                  w_any_fault;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_epc_sel;
    logic [DATA_WIDTH-1:0] w_cause_sel;
    logic [DATA_WIDTH-1:0] w_tval_sel;
    logic                  w_flush_nxt;
    logic                  w_stall_nxt;
    logic                  w_redirect_vld_nxt;
    logic [DATA_WIDTH-1:0] w_redirect_addr_nxt;
    logic                  w_trap_active_nxt;
    logic                  w_halted_nxt;

    jedro_1_align_chk #(
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_jmp_align (
        .addr_i       (jmp_target_i[2:0]),
        .size_i       (LS_WORD),
        .inst_i       (1'b1),
        .ialign16_i   (IALIGN16),
        .misaligned_o (w_jmp_mis)
    );

    jedro_1_align_chk #(
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_ls_align (
        .addr_i       (ls_addr_i[2:0]),
        .size_i       (ls_size_e'(ls_size_i)),
        .inst_i       (1'b0),
        .ialign16_i   (1'b0),
        .misaligned_o (w_ls_mis)
    );

    assign w_jmp_fault = jmp_valid_i & w_jmp_mis;
    assign w_ls_fault  = ls_valid_i & w_ls_mis;
    assign w_any_fault = w_jmp_fault | w_ls_fault | illegal_i;

    // The MEM-stage access is the oldest instruction, then EX jump, then decode.
    always_comb begin
        w_epc_sel   = illegal_pc_i;
        w_cause_sel = DATA_WIDTH'(CAUSE_ILLEGAL_INSTR);
        w_tval_sel  = DATA_WIDTH'(illegal_word_i);
        if (w_ls_fault) begin
            w_epc_sel   = ls_pc_i;
            w_cause_sel = ls_we_i ? DATA_WIDTH'(CAUSE_STORE_MISALIGN)
                                  : DATA_WIDTH'(CAUSE_LOAD_MISALIGN);
            w_tval_sel  = ls_addr_i;
        end else if (w_jmp_fault) begin
            w_epc_sel   = jmp_pc_i;
            w_cause_sel = DATA_WIDTH'(CAUSE_INSTR_MISALIGN);
            w_tval_sel  = jmp_target_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_fault) begin
                    w_state_nxt = ST_FLUSH;
                    w_drain_nxt = DRAIN_LAST;
                    w_capture   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (r_drain_cnt == 3'd0) begin
                    w_state_nxt = ST_REDIRECT;
                end else begin
                    w_drain_nxt = r_drain_cnt - 3'd1;
                end
            end
            ST_REDIRECT: w_state_nxt = ST_HANDLER;
            ST_HANDLER: begin
                // A fault inside the handler wins over a simultaneous mret.
                if (w_any_fault) begin
                    w_state_nxt = ST_HALT;
                end else if (mret_i) begin
                    w_state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: w_state_nxt = ST_IDLE;
            ST_HALT:   w_state_nxt = ST_HALT;
            default:   w_state_nxt = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        w_flush_nxt         = (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_RETURN);
        w_stall_nxt         = (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_HALT);
        w_redirect_vld_nxt  = (w_state_nxt == ST_REDIRECT) || (w_state_nxt == ST_RETURN);
        w_trap_active_nxt   = (w_state_nxt == ST_HANDLER) || (w_state_nxt == ST_RETURN);
        w_halted_nxt        = (w_state_nxt == ST_HALT);
        w_redirect_addr_nxt = r_redirect_addr;
        if (w_state_nxt == ST_REDIRECT) begin
            w_redirect_addr_nxt = mtvec_i & VEC_MASK;
        end else if (w_state_nxt == ST_RETURN) begin
            w_redirect_addr_nxt = r_mepc;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_flush         <= 1'b0;
            r_stall         <= 1'b0;
            r_redirect_vld  <= 1'b0;
            r_redirect_addr <= '0;
            r_mepc          <= '0;
            r_mcause        <= '0;
            r_mtval         <= '0;
            r_trap_active   <= 1'b0;
            r_halted        <= 1'b0;
            r_count         <= '0;
        end else begin
            r_flush         <= w_flush_nxt;
            r_stall         <= w_stall_nxt;
            r_redirect_vld  <= w_redirect_vld_nxt;
            r_redirect_addr <= w_redirect_addr_nxt;
            r_trap_active   <= w_trap_active_nxt;
            r_halted        <= w_halted_nxt;
            if (w_capture) begin
                r_mepc   <= w_epc_sel;
                r_mcause <= w_cause_sel;
                r_mtval  <= w_tval_sel;
                if (r_count != '1) begin
                    r_count <= r_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign flush_o          = r_flush;
    assign stall_o          = r_stall;
    assign redirect_valid_o = r_redirect_vld;
    assign redirect_addr_o  = r_redirect_addr;
    assign mepc_o           = r_mepc;
    assign mcause_o         = r_mcause;
    assign mtval_o          = r_mtval;
    assign trap_active_o    = r_trap_active;
    assign halted_o         = r_halted;
    assign excp_count_o     = r_count;

endmodule

// File: tb/tb_jedro_1_excp_unit.sv
// Bench for jedro_1_excp_unit: a directed vector table, hand sequences and random stimulus vs. a timeline model.
// Two instances share inputs: IALIGN=32 with a 3-bit counter, and IALIGN=16 with an 8-bit counter.
// Outputs are sampled 1 time unit after each rising edge.
module tb_jedro_1_excp_unit;

    localparam int D = 2;

    typedef struct packed {
        logic        flush;
        logic        stall;
        logic        rv;
        logic [31:0] raddr;
        logic        ta;
        logic        halt;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [7:0]  cnt;
    } obs_t;

    typedef struct packed {
        logic        jv;
        logic [31:0] jpc;
        logic [31:0] jtgt;
        logic        lv;
        logic        lwe;
        logic [1:0]  lsz;
        logic [31:0] lpc;
        logic [31:0] laddr;
        logic        il;
        logic [31:0] ipc;
        logic [31:0] iword;
        logic        mret;
        logic [31:0] mtvec;
        obs_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        jmp_valid, ls_valid, ls_we, illegal, mret;
    logic [31:0] jmp_pc, jmp_target, ls_pc, ls_addr, illegal_pc, illegal_word, mtvec;
    logic [1:0]  ls_size;

    logic        f0, s0, rv0, ta0, h0, f1, s1, rv1, ta1, h1;
    logic [31:0] ra0, mepc0, mc0, mt0, ra1, mepc1, mc1, mt1;
    logic [2:0]  cnt0;
    logic [7:0]  cnt1;
    obs_t        o0, o1;

    always #5 clk = ~clk;

    jedro_1_excp_unit #(
        .DATA_WIDTH(32), .IALIGN(32), .DRAIN_CYCLES(D), .CNT_WIDTH(3)
    ) u_dut32 (
        .clk_i(clk), .rstn_i(rstn),
        .jmp_valid_i(jmp_valid), .jmp_pc_i(jmp_pc), .jmp_target_i(jmp_target),
        .ls_valid_i(ls_valid), .ls_we_i(ls_we), .ls_size_i(ls_size),
        .ls_pc_i(ls_pc), .ls_addr_i(ls_addr),
        .illegal_i(illegal), .illegal_pc_i(illegal_pc), .illegal_word_i(illegal_word),
        .mret_i(mret), .mtvec_i(mtvec),
        .flush_o(f0), .stall_o(s0), .redirect_valid_o(rv0), .redirect_addr_o(ra0),
        .mepc_o(mepc0), .mcause_o(mc0), .mtval_o(mt0),
        .trap_active_o(ta0), .halted_o(h0), .excp_count_o(cnt0)
    );

    jedro_1_excp_unit #(
        .DATA_WIDTH(32), .IALIGN(16), .DRAIN_CYCLES(D), .CNT_WIDTH(8)
    ) u_dut16 (
        .clk_i(clk), .rstn_i(rstn),
        .jmp_valid_i(jmp_valid), .jmp_pc_i(jmp_pc), .jmp_target_i(jmp_target),
        .ls_valid_i(ls_valid), .ls_we_i(ls_we), .ls_size_i(ls_size),
        .ls_pc_i(ls_pc), .ls_addr_i(ls_addr),
        .illegal_i(illegal), .illegal_pc_i(illegal_pc), .illegal_word_i(illegal_word),
        .mret_i(mret), .mtvec_i(mtvec),
        .flush_o(f1), .stall_o(s1), .redirect_valid_o(rv1), .redirect_addr_o(ra1),
        .mepc_o(mepc1), .mcause_o(mc1), .mtval_o(mt1),
        .trap_active_o(ta1), .halted_o(h1), .excp_count_o(cnt1)
    );

    assign o0 = {f0, s0, rv0, ra0, ta0, h0, mepc0, mc0, mt0, {5'd0, cnt0}};
    assign o1 = {f1, s1, rv1, ra1, ta1, h1, mepc1, mc1, mt1, cnt1};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a taken trap at edge T flushes after edges T..T+D-1, redirects after T+D,
    // and is in the handler from T+D+1 until an mret edge R, which is the single return cycle.
    int          k = 0;
    bit          m_halt[2];
    int          m_trap[2];
    int          m_ret[2];
    int          m_cnt[2];
    logic [31:0] m_mepc[2], m_mcause[2], m_mtval[2], m_raddr[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_halt[i] = 0; m_trap[i] = -1; m_ret[i] = -1; m_cnt[i] = 0;
            m_mepc[i] = 0; m_mcause[i] = 0; m_mtval[i] = 0; m_raddr[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int ialign, input int cmax);
        bit lf, jf, any, pidle, phand, pret;
        lf = ls_valid && ((ls_size == 2'd3) || ((ls_addr % (32'd1 << ls_size)) != 0));
        jf = jmp_valid && ((jmp_target % 32'(ialign / 8)) != 0);
        any = lf || jf || illegal;
        pidle = !m_halt[i] && (m_trap[i] < 0);
        phand = !m_halt[i] && (m_trap[i] >= 0) && (m_ret[i] < 0) && ((k - 1 - m_trap[i]) > D);
        pret  = !m_halt[i] && (m_ret[i] >= 0) && (m_ret[i] == k - 1);
        if (pidle && any) begin
            if (lf) begin
                m_mcause[i] = ls_we ? 32'd6 : 32'd4; m_mtval[i] = ls_addr; m_mepc[i] = ls_pc;
            end else if (jf) begin
                m_mcause[i] = 32'd0; m_mtval[i] = jmp_target; m_mepc[i] = jmp_pc;
            end else begin
                m_mcause[i] = 32'd2; m_mtval[i] = illegal_word; m_mepc[i] = illegal_pc;
            end
            m_trap[i] = k;
            if (m_cnt[i] < cmax) m_cnt[i]++;
        end else if (phand) begin
            if (any) m_halt[i] = 1;
            else if (mret) begin
                m_ret[i] = k; m_raddr[i] = m_mepc[i];
            end
        end else if (pret) begin
            m_trap[i] = -1; m_ret[i] = -1;
        end
        if (!m_halt[i] && m_trap[i] >= 0 && (k - m_trap[i]) == D) m_raddr[i] = mtvec & ~32'd3;
    endtask

    function automatic obs_t exp_obs(input int i);
        obs_t e;
        int   d;
        bit   tr, isret;
        e     = '0;
        d     = k - m_trap[i];
        tr    = !m_halt[i] && (m_trap[i] >= 0);
        isret = tr && (m_ret[i] == k);
        e.flush  = tr && ((d < D) || isret);
        e.stall  = m_halt[i] || (tr && d < D);
        e.rv     = tr && ((d == D) || isret);
        e.raddr  = m_raddr[i];
        e.ta     = tr && (d > D);
        e.halt   = m_halt[i];
        e.mepc   = m_mepc[i];
        e.mcause = m_mcause[i];
        e.mtval  = m_mtval[i];
        e.cnt    = 8'(m_cnt[i]);
        return e;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, "_flush"}, 32'(a.flush), 32'(e.flush));
        chk({tag, "_stall"}, 32'(a.stall), 32'(e.stall));
        chk({tag, "_redir_vld"}, 32'(a.rv), 32'(e.rv));
        if (e.rv) chk({tag, "_redir_addr"}, a.raddr, e.raddr);
        chk({tag, "_trap_active"}, 32'(a.ta), 32'(e.ta));
        chk({tag, "_halted"}, 32'(a.halt), 32'(e.halt));
        chk({tag, "_mepc"}, a.mepc, e.mepc);
        chk({tag, "_mcause"}, a.mcause, e.mcause);
        chk({tag, "_mtval"}, a.mtval, e.mtval);
        chk({tag, "_count"}, 32'(a.cnt), 32'(e.cnt));
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        model_step(0, 32, 7);
        model_step(1, 16, 255);
        #1;
        cmp_obs("m32", o0, exp_obs(0));
        cmp_obs("m16", o1, exp_obs(1));
    endtask

    task automatic idle_in();
        jmp_valid = 0; ls_valid = 0; illegal = 0; mret = 0;
    endtask

    task automatic chk_zero(input string tag, input obs_t a);
        obs_t z;
        z = '0;
        z.raddr = 32'd0;
        cmp_obs(tag, a, z);
        chk({tag, "_redir_addr_rst"}, a.raddr, 32'd0);
    endtask

    task automatic do_reset();
        rstn = 0;
        #1;
        model_reset();
        chk_zero("rst32", o0);
        chk_zero("rst16", o1);
        @(negedge clk);
        rstn = 1;
    endtask

    vec_t tbl[26];

    task automatic r_exp(input int i, input bit f, input bit s, input bit rv, input logic [31:0] ra,
                         input bit ta, input bit h, input logic [31:0] mc, input logic [31:0] ep,
                         input logic [31:0] tv, input int cnt);
        tbl[i].e = {f, s, rv, ra, ta, h, ep, mc, tv, 8'(cnt)};
    endtask

    task automatic fill_table();
        for (int i = 0; i < 26; i++) begin
            tbl[i] = '0;
            tbl[i].mtvec = 32'h100;
        end
        tbl[0].jv = 1; tbl[0].jpc = 32'h10; tbl[0].jtgt = 32'h22;
        r_exp(0, 1, 1, 0, 0, 0, 0, 0, 32'h10, 32'h22, 1);
        r_exp(1, 1, 1, 0, 0, 0, 0, 0, 32'h10, 32'h22, 1);
        r_exp(2, 0, 0, 1, 32'h100, 0, 0, 0, 32'h10, 32'h22, 1);
        r_exp(3, 0, 0, 0, 0, 1, 0, 0, 32'h10, 32'h22, 1);
        tbl[4].mret = 1;
        r_exp(4, 1, 0, 1, 32'h10, 1, 0, 0, 32'h10, 32'h22, 1);
        r_exp(5, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h22, 1);
        // store word 0x1002 + jump to 0x5 + illegal in one cycle: the store wins
        tbl[6].lv = 1; tbl[6].lwe = 1; tbl[6].lsz = 2; tbl[6].lpc = 32'h40; tbl[6].laddr = 32'h1002;
        tbl[6].jv = 1; tbl[6].jpc = 32'h44; tbl[6].jtgt = 32'h5;
        tbl[6].il = 1; tbl[6].ipc = 32'h48; tbl[6].iword = 32'hFFFF_FFFF;
        for (int i = 6; i <= 8; i++) tbl[i].mtvec = 32'h203;
        r_exp(6, 1, 1, 0, 0, 0, 0, 6, 32'h40, 32'h1002, 2);
        tbl[7].il = 1; tbl[7].ipc = 32'h50; tbl[7].iword = 32'h13;
        r_exp(7, 1, 1, 0, 0, 0, 0, 6, 32'h40, 32'h1002, 2);
        r_exp(8, 0, 0, 1, 32'h200, 0, 0, 6, 32'h40, 32'h1002, 2);
        r_exp(9, 0, 0, 0, 0, 1, 0, 6, 32'h40, 32'h1002, 2);
        tbl[10].mret = 1;
        r_exp(10, 1, 0, 1, 32'h40, 1, 0, 6, 32'h40, 32'h1002, 2);
        tbl[11].lv = 1; tbl[11].lsz = 1; tbl[11].lpc = 32'h70; tbl[11].laddr = 32'h5;
        r_exp(11, 0, 0, 0, 0, 0, 0, 6, 32'h40, 32'h1002, 2);
        tbl[12].lv = 1; tbl[12].lsz = 1; tbl[12].lpc = 32'h80; tbl[12].laddr = 32'h3;
        r_exp(12, 1, 1, 0, 0, 0, 0, 4, 32'h80, 32'h3, 3);
        r_exp(13, 1, 1, 0, 0, 0, 0, 4, 32'h80, 32'h3, 3);
        r_exp(14, 0, 0, 1, 32'h100, 0, 0, 4, 32'h80, 32'h3, 3);
        r_exp(15, 0, 0, 0, 0, 1, 0, 4, 32'h80, 32'h3, 3);
        tbl[16].mret = 1;
        r_exp(16, 1, 0, 1, 32'h80, 1, 0, 4, 32'h80, 32'h3, 3);
        r_exp(17, 0, 0, 0, 0, 0, 0, 4, 32'h80, 32'h3, 3);
        tbl[18].jv = 1; tbl[18].jpc = 32'h90; tbl[18].jtgt = 32'h94;
        r_exp(18, 0, 0, 0, 0, 0, 0, 4, 32'h80, 32'h3, 3);
        tbl[19].il = 1; tbl[19].ipc = 32'hA0; tbl[19].iword = 32'h1234_5678;
        r_exp(19, 1, 1, 0, 0, 0, 0, 2, 32'hA0, 32'h1234_5678, 4);
        r_exp(20, 1, 1, 0, 0, 0, 0, 2, 32'hA0, 32'h1234_5678, 4);
        r_exp(21, 0, 0, 1, 32'h100, 0, 0, 2, 32'hA0, 32'h1234_5678, 4);
        r_exp(22, 0, 0, 0, 0, 1, 0, 2, 32'hA0, 32'h1234_5678, 4);
        tbl[23].il = 1; tbl[23].ipc = 32'hB0; tbl[23].iword = 32'hDEAD;
        r_exp(23, 0, 1, 0, 0, 0, 1, 2, 32'hA0, 32'h1234_5678, 4);
        tbl[24].mret = 1;
        r_exp(24, 0, 1, 0, 0, 0, 1, 2, 32'hA0, 32'h1234_5678, 4);
        tbl[25].lv = 1; tbl[25].lsz = 2; tbl[25].laddr = 32'h7;
        r_exp(25, 0, 1, 0, 0, 0, 1, 2, 32'hA0, 32'h1234_5678, 4);
    endtask

    initial begin
        idle_in();
        jmp_pc = 0; jmp_target = 0; ls_we = 0; ls_size = 0; ls_pc = 0; ls_addr = 0;
        illegal_pc = 0; illegal_word = 0; mtvec = 32'h100;
        model_reset();
        fill_table();

        #12;
        chk_zero("init32", o0);
        chk_zero("init16", o1);
        @(negedge clk);
        rstn = 1;

        for (int i = 0; i < 26; i++) begin
            jmp_valid = tbl[i].jv;   jmp_pc = tbl[i].jpc;   jmp_target = tbl[i].jtgt;
            ls_valid = tbl[i].lv;    ls_we = tbl[i].lwe;    ls_size = tbl[i].lsz;
            ls_pc = tbl[i].lpc;      ls_addr = tbl[i].laddr;
            illegal = tbl[i].il;     illegal_pc = tbl[i].ipc; illegal_word = tbl[i].iword;
            mret = tbl[i].mret;      mtvec = tbl[i].mtvec;
            step();
            cmp_obs($sformatf("tbl%0d", i), o0, tbl[i].e);
            if (i == 0) chk("i16_even_target_no_flush", 32'(f1), 32'd0);
        end
        idle_in();

        // IALIGN=16: odd target faults, and reset lands in the middle of FLUSH.
        do_reset();
        jmp_valid = 1; jmp_pc = 32'h10; jmp_target = 32'h23; mtvec = 32'h100;
        step();
        idle_in();
        chk("i16_odd_mcause", mc1, 32'd0);
        chk("i16_odd_mtval", mt1, 32'h23);
        chk("i16_odd_flush", 32'(f1), 32'd1);
        do_reset();
        for (int n = 0; n < 6; n++) begin
            step();
            chk("post_reset_no_redir32", 32'(rv0), 32'd0);
            chk("post_reset_no_redir16", 32'(rv1), 32'd0);
        end

        // Nine trap/mret round trips: the 3-bit counter must stop at 7.
        for (int n = 0; n < 9; n++) begin
            illegal = 1; illegal_pc = 32'h200 + 32'(n * 4); illegal_word = 32'(n);
            step();
            illegal = 0;
            for (int c = 0; c < D + 1; c++) step();
            mret = 1;
            step();
            mret = 0;
            step();
        end
        chk("sat_count32", 32'(cnt0), 32'd7);
        chk("sat_count16", 32'(cnt1), 32'd9);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            jmp_valid    = ($urandom_range(7) == 0);
            jmp_pc       = $urandom;
            jmp_target   = $urandom;
            ls_valid     = ($urandom_range(7) == 0);
            ls_we        = $urandom_range(1);
            ls_size      = 2'($urandom_range(3));
            ls_pc        = $urandom;
            ls_addr      = $urandom;
            illegal      = ($urandom_range(15) == 0);
            illegal_pc   = $urandom;
            illegal_word = $urandom;
            mret         = ($urandom_range(3) == 0);
            mtvec        = $urandom;
            step();
            if ((m_halt[0] || m_halt[1]) && ($urandom_range(3) == 0)) do_reset();
            else if ($urandom_range(299) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
